// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain.
// Each stage has a valid bit and uses a valid/ready handshake.
// Any stage can be frozen (stall) or flushed (bubble insert).
// An empty stage always takes new data unless frozen, so bubbles collapse under backpressure.
// Ready travels combinationally from out_ready back to in_ready.
module pipe_stage_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   input  logic [DEPTH-1:0]             freeze,
   input  logic [DEPTH-1:0]             flush,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int OCC_W = $clog2(DEPTH+1);
   localparam int INC_W = $clog2(2*DEPTH+1);
   localparam int SUM_W = CNT_W + INC_W;

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];

   logic [DEPTH:0]   acc;
   logic [DEPTH-1:0] go;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [INC_W-1:0] drop_inc;
   logic [SUM_W-1:0] drop_sum;
   logic [CNT_W-1:0] drop_next;
   logic [OCC_W-1:0] occ;

   // Ready ripple, evaluated from the sink back to the source.
   // A flushed stage always accepts, so the stage above it can still release.
   always_comb begin
      acc        = '0;
      go         = '0;
      acc[DEPTH] = out_ready;
      for (int i = DEPTH-1; i >= 0; i--) begin
         go[i]  = valid[i] & ~freeze[i] & acc[i+1];
         acc[i] = flush[i] | (~freeze[i] & (~valid[i] | go[i]));
      end
   end

   // Source of each stage: the input port for stage 0, otherwise the releasing stage above it.
   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = go[i-1];
         src_d[i] = data[i-1];
      end
   end

   // Count the valid entries a flush destroys:
   // - a flushed stage's own item, if it does not leave this cycle;
   // - an item that moves into a flushed stage.
   always_comb begin
      drop_inc = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush[i]) begin
            if (valid[i] & ~go[i])
               drop_inc = drop_inc + INC_W'(1);
            if (src_v[i])
               drop_inc = drop_inc + INC_W'(1);
         end
      end
      drop_sum  = SUM_W'(drop_cnt) + SUM_W'(drop_inc);
      drop_next = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   // Popcount of the registered valid bits.
   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++)
         occ = occ + OCC_W'(valid[i]);
   end

   // Stage registers and drop counter.
   // A flush wins over a freeze.
   // A stage that loads a bubble keeps its stale data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++)
            data[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
               valid[i] <= 1'b0;
               data[i]  <= '0;
            end else if (acc[i]) begin
               valid[i] <= src_v[i];
               if (src_v[i])
                  data[i] <= src_d[i];
            end
         end
         drop_cnt <= drop_next;
      end
   end

   assign in_ready    = acc[0];
   assign out_valid   = valid[DEPTH-1] & ~freeze[DEPTH-1];
   assign out_data    = data[DEPTH-1];
   assign stage_valid = valid;
   assign occupancy   = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with DEPTH=5, WIDTH=32.
module tb_pipe_stage_chain;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [4:0]  freeze;
   logic [4:0]  flush;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [4:0]  stage_valid;
   logic [2:0]  occupancy;
   logic [15:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage_chain #(.WIDTH(32), .DEPTH(5), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .freeze      (freeze),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .stage_valid (stage_valid),
      .occupancy   (occupancy),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_chain();
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      freeze    = '0;
      flush     = '0;
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      freeze    = '0;
      flush     = '0;
      out_ready = 1'b0;

      // Reset state, checked before the first clock edge.
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_occ",       32'(occupancy), 32'd0);
      chk("rst_drop",      32'(drop_cnt), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      freeze = 5'b00001;
      #1;
      chk("rst_in_ready_frz0", 32'(in_ready), 32'd0);
      freeze = '0;
      tick();
      rst = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_valid",    32'(stage_valid), 32'd0);

      // Stream at full rate.
      // Item 0 is presented before edge 1 and reaches out_data after edge 5.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         in_data = 32'h100 + 32'(4*(c-1));
         #1;
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         tick();
         if (c >= 5) begin
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_out_data",  out_data, 32'h100 + 32'(4*(c-5)));
         end else begin
            chk("stream_fill_valid", 32'(out_valid), 32'd0);
         end
      end

      // Backpressure: five accepts fill the pipe.
      // Then a single out_ready pulse lets exactly one item leave and one enter.
      reset_chain();
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 32'h200 + 32'(4*k);
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd1);
         tick();
      end
      in_data = 32'h214;
      #1;
      chk("bp_full_in_ready", 32'(in_ready), 32'd0);
      chk("bp_full_occ",      32'(occupancy), 32'd5);
      chk("bp_head",          out_data, 32'h200);
      out_ready = 1'b1;
      #1;
      chk("bp_pulse_in_ready", 32'(in_ready), 32'd1);
      tick();
      out_ready = 1'b0;
      in_data   = 32'h218;
      #1;
      chk("bp_after_occ",      32'(occupancy), 32'd5);
      chk("bp_after_head",     out_data, 32'h204);
      chk("bp_after_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold_head",      out_data, 32'h204);

      // Gapped input under backpressure, with the pattern 1,0,1,0,1.
      // Two more idle cycles close the gaps into stages 4,3,2.
      reset_chain();
      for (int k = 0; k < 7; k++) begin
         in_valid = (k < 5) && (k % 2 == 0);
         in_data  = 32'h300 + 32'(4*k);
         tick();
         if (k == 4) chk("gap_sv_e5", 32'(stage_valid), 32'b10101);
      end
      chk("gap_sv_packed", 32'(stage_valid), 32'b11100);
      chk("gap_occ",       32'(occupancy), 32'd3);
      out_ready = 1'b1;
      #1;
      chk("gap_out0", out_data, 32'h300);
      tick();
      chk("gap_out1", out_data, 32'h308);
      tick();
      chk("gap_out2", out_data, 32'h310);
      tick();
      chk("gap_empty", 32'(out_valid), 32'd0);

      // Flush of stages 0-1 on a full, stalled pipe.
      // Stage 1's own item is destroyed, and stage 0's item moves into stage 1 and is discarded: two drops.
      reset_chain();
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 32'h400 + 32'(4*k);
         tick();
      end
      in_valid = 1'b0;
      flush    = 5'b00011;
      #1;
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = '0;
      chk("fl_sv",   32'(stage_valid), 32'b11100);
      chk("fl_drop", 32'(drop_cnt), 32'd2);
      out_ready = 1'b1;
      #1;
      chk("fl_out0", out_data, 32'h400);
      tick();
      chk("fl_out1", out_data, 32'h404);
      tick();
      chk("fl_out2", out_data, 32'h408);
      tick();
      chk("fl_empty", 32'(out_valid), 32'd0);

      // Freeze stage 2 while the stages below it are empty.
      // Stages 3-4 drain, stages 0-1 fill, and in_ready drops after two accepts.
      reset_chain();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = (k < 3);
         in_data  = 32'h600 + 32'(4*k);
         tick();
      end
      chk("fz_pre_sv", 32'(stage_valid), 32'b11100);
      freeze   = 5'b00100;
      in_valid = 1'b1;
      in_data  = 32'h60c;
      #1;
      chk("fz_in_ready0", 32'(in_ready), 32'd1);
      chk("fz_out0",      out_data, 32'h600);
      tick();
      in_data = 32'h610;
      #1;
      chk("fz_in_ready1", 32'(in_ready), 32'd1);
      chk("fz_out1",      out_data, 32'h604);
      tick();
      in_data = 32'h614;
      #1;
      chk("fz_in_ready2", 32'(in_ready), 32'd0);
      chk("fz_sv",        32'(stage_valid), 32'b00111);
      chk("fz_out_valid", 32'(out_valid), 32'd0);

      // Freeze and flush stage 2 together; the flush wins.
      // Two drops: stage 2's own item, and the item stage 1 releases into stage 2.
      flush = 5'b00100;
      #1;
      chk("ff_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = '0;
      chk("ff_sv",   32'(stage_valid), 32'b00011);
      chk("ff_drop", 32'(drop_cnt), 32'd2);

      // Reset asserted mid-cycle clears everything at once.
      freeze = '0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_out_data",  out_data, 32'd0);
      chk("mr_occ",       32'(occupancy), 32'd0);
      chk("mr_drop",      32'(drop_cnt), 32'd0);
      chk("mr_in_ready",  32'(in_ready), 32'd1);
      chk("mr_sv",        32'(stage_valid), 32'd0);
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
